srn_universal_shift: RTL and testbench
======================================

Name: srn_universal_shift

Overview:
- Parametrised universal shift register. Successor to the fixed 4-bit serial-in, clock-enabled, resettable shift register.
- Adds:
  - generic width and reset value;
  - shift-left, shift-right and parallel-load modes;
  - serial outputs at both ends;
  - a shift counter that flags when a full word has been shifted.
- Used as a generic serialiser/deserialiser stage in front of simple serial links and in lab exercises.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- INIT, {WIDTH{1'b0}}, value loaded into Q on reset.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- R  input  1  reset, synchronous, active-high.
- CE  input  1  clock enable; gates every state change except reset.
- MODE  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load.
- SLI  input  1  serial input for shift left; enters Q[0].
- SRI  input  1  serial input for shift right; enters Q[WIDTH-1].
- ROT  input  1  rotate request; honoured only with SRN_ROTATE_EN.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  register contents.
- SLO  output  1  equals Q[WIDTH-1]; combinational from Q.
- SRO  output  1  equals Q[0]; combinational from Q.
- CNT  output  CW  shifts since last load/reset; CW = $clog2(WIDTH+1).
- FULL  output  1  level; high when CNT == WIDTH.
- DONE  output  1  registered one-cycle pulse when CNT transitions to WIDTH.

Behaviour:
- Single clock domain, synchronous active-high reset, no asynchronous paths.
- Reset (R=1 at a CLK edge):
  - Q=INIT, CNT=0, DONE=0.
  - FULL follows CNT, so FULL=0.
  - R has priority over CE and MODE.
  - Reset mid-shift discards the word in progress.
- CE=0: Q and CNT hold; DONE=0 the following cycle.
- CE=1, MODE=00: Q and CNT hold; DONE=0.
- CE=1, MODE=01 (shift left):
  - Q <= {Q[WIDTH-2:0], SLI}.
  - CNT <= CNT+1, saturating at WIDTH.
- CE=1, MODE=10 (shift right):
  - Q <= {SRI, Q[WIDTH-1:1]}.
  - CNT <= CNT+1, saturating at WIDTH.
- CE=1, MODE=11 (parallel load): Q <= D; CNT <= 0; DONE=0.
- Latency: Q, CNT, DONE all update at the same edge as the triggering operation.
- DONE:
  - Set for exactly one cycle at the edge where CNT goes WIDTH-1 -> WIDTH.
  - Further shifts while saturated at WIDTH do not re-assert DONE.
  - A load or reset re-arms DONE.
- Mixing left and right shifts is legal; both increment CNT.
- FULL = (CNT == WIDTH), decoded combinationally from CNT.

Optional Feature:
- Macro: SRN_ROTATE_EN.
- Defined: when CE=1 and ROT=1, shift modes rotate instead of taking serial inputs.
  - MODE=01: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - MODE=10: Q <= {Q[0], Q[WIDTH-1:1]}.
  - CNT and DONE behave exactly as for a normal shift.
  - ROT is ignored for MODE 00 and 11.
- Not defined: ROT is ignored entirely; SLI/SRI are always used; no extra logic synthesised.

Test Plan:
- Reset check, WIDTH=8, INIT=8'hA5: R=1 for 2 cycles -> Q=8'hA5, CNT=0, FULL=0, DONE=0. Then CE=0 for 10 cycles -> Q stays 8'hA5.
- Shift-left fill: after reset with INIT=0, CE=1, MODE=01, SLI=1 for 8 cycles.
  - Q goes 01, 03, 07, ..., FF.
  - CNT goes 1..8.
  - DONE high only on the 8th edge; FULL high from the 8th edge on.
  - 4 further shifts -> DONE stays 0, CNT stays 8.
- Load and shift right: MODE=11, D=8'h96 -> Q=96, CNT=0. Then MODE=10, SRI=0 for 8 cycles -> SRO sequence 0,1,1,0,1,0,0,1; final Q=00; DONE pulses once.
- CE gating mid-word: load 8'hF0, shift left 3 times with SLI=0 (Q=80, CNT=3). Then CE=0 for 5 cycles -> Q=80, CNT=3, DONE=0. Then R=1 with CE=0 -> Q=INIT, CNT=0.
- Rotate, with SRN_ROTATE_EN defined: load 8'h81, ROT=1, MODE=01 for 8 cycles -> Q returns to 8'h81, DONE pulses on the 8th edge. Same stimulus without the macro and SLI=0 -> Q=8'h00.

Source files
------------

// File: rtl/srn_universal_shift.sv
// ---------------------------------------------------------------------------
// srn_universal_shift
// Parametrised universal shift register. It can hold, shift left, shift right
// or parallel-load the word, and it drives a serial output at each end.
// A saturating counter tracks the shifts made since the last load or reset.
// FULL is a level that decodes a completed word. DONE is a one-cycle pulse
// raised on the shift that completes the word.
//
// Optional feature: define SRN_ROTATE_EN to make ROT turn both shift modes
// into rotates. When SRN_ROTATE_EN is undefined, ROT is ignored and no
// rotate logic is built.
// ---------------------------------------------------------------------------
module srn_universal_shift #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic                       CLK,
    input  logic                       R,
    input  logic                       CE,
    input  logic [1:0]                 MODE,
    input  logic                       SLI,
    input  logic                       SRI,
    input  logic                       ROT,
    input  logic [WIDTH-1:0]           D,
    output logic [WIDTH-1:0]           Q,
    output logic                       SLO,
    output logic                       SRO,
    output logic [$clog2(WIDTH+1)-1:0] CNT,
    output logic                       FULL,
    output logic                       DONE
);

    localparam int CW = $clog2(WIDTH + 1);

    // The counter saturates at CNT_FULL. CNT_LAST is the count just before a
    // word completes, which is the only count from which DONE can fire.
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_t;

    mode_t           mode;
    logic            left_in;
    logic            right_in;
    logic [CW-1:0]   cnt_inc;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]   cnt_next;
    logic            done_next;

    assign mode = mode_t'(MODE);

`ifdef SRN_ROTATE_EN
    // Select the bit that enters the vacated end. With ROT set, each shift
    // mode feeds back the bit that leaves the opposite end, so the shift
    // becomes a rotate.
    always_comb begin
        left_in  = ROT ? Q[WIDTH-1] : SLI;
        right_in = ROT ? Q[0]       : SRI;
    end
`else
    // Rotation is compiled out, so the serial inputs always fill the vacated
    // end. ROT is still a port and is tied off here.
    logic unused_rot;
    assign unused_rot = ROT;
    assign left_in    = SLI;
    assign right_in   = SRI;
`endif

    // Increment the shift count, holding it once a whole word has gone by.
    // Further shifts past that point never wrap the counter.
    assign cnt_inc = (CNT == CNT_FULL) ? CNT_FULL : CNT + CW'(1);

    // Compute the next register state. Hold is the default for every field.
    // DONE is raised only by the shift that takes the counter from the last
    // partial count to full. Hold, load and a low CE all leave DONE low.
    always_comb begin
        q_next    = Q;
        cnt_next  = CNT;
        done_next = 1'b0;
        if (CE) begin
            case (mode)
                MODE_LEFT: begin
                    q_next    = {Q[WIDTH-2:0], left_in};
                    cnt_next  = cnt_inc;
                    done_next = (CNT == CNT_LAST);
                end
                MODE_RIGHT: begin
                    q_next    = {right_in, Q[WIDTH-1:1]};
                    cnt_next  = cnt_inc;
                    done_next = (CNT == CNT_LAST);
                end
                MODE_LOAD: begin
                    q_next   = D;
                    cnt_next = '0;
                end
                default: begin
                    q_next = Q;
                end
            endcase
        end
    end

    // Register the state. A synchronous reset beats CE and MODE, and it
    // throws away any partly shifted word.
    always_ff @(posedge CLK) begin
        if (R) begin
            Q    <= INIT;
            CNT  <= '0;
            DONE <= 1'b0;
        end else begin
            Q    <= q_next;
            CNT  <= cnt_next;
            DONE <= done_next;
        end
    end

    assign SLO  = Q[WIDTH-1];
    assign SRO  = Q[0];
    assign FULL = (CNT == CNT_FULL);

endmodule

// File: tb/tb_srn_universal_shift.sv
// ---------------------------------------------------------------------------
// tb_srn_universal_shift
// Self-checking bench for srn_universal_shift, built with WIDTH=8 and
// INIT=8'hA5. A behavioural model written with integer arithmetic predicts
// every output after every clock edge. The bench first walks through the
// directed scenarios and then applies a randomised run.
// ---------------------------------------------------------------------------
module tb_srn_universal_shift;

    localparam int         W        = 8;
    localparam logic [7:0] INIT_VAL = 8'hA5;

    logic       CLK = 1'b0;
    logic       R;
    logic       CE;
    logic [1:0] MODE;
    logic       SLI;
    logic       SRI;
    logic       ROT;
    logic [7:0] D;
    logic [7:0] Q;
    logic       SLO;
    logic       SRO;
    logic [3:0] CNT;
    logic       FULL;
    logic       DONE;

    int          checks = 0;
    int          errors = 0;
    int unsigned m_q    = 0;
    int          m_cnt  = 0;
    bit          m_done = 1'b0;
    int          done_seen;
    bit          exp_sro [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    srn_universal_shift #(.WIDTH(W), .INIT(INIT_VAL)) dut (
        .CLK (CLK),
        .R   (R),
        .CE  (CE),
        .MODE(MODE),
        .SLI (SLI),
        .SRI (SRI),
        .ROT (ROT),
        .D   (D),
        .Q   (Q),
        .SLO (SLO),
        .SRO (SRO),
        .CNT (CNT),
        .FULL(FULL),
        .DONE(DONE)
    );

    // Free-running clock with a 10-time-unit period.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("q",    64'(Q),    64'(m_q));
        checkOutput("slo",  64'(SLO),  64'(m_q / 128));
        checkOutput("sro",  64'(SRO),  64'(m_q % 2));
        checkOutput("cnt",  64'(CNT),  64'(m_cnt));
        checkOutput("full", 64'(FULL), 64'(m_cnt == W));
        checkOutput("done", 64'(DONE), 64'(m_done));
    endtask

    // Advance the reference model by one clock edge. The rules are the
    // behavioural ones: multiply or divide for the shifts, and a count that
    // never goes past W.
    task automatic modelStep(input bit r, input bit ce, input int md, input bit sli,
                             input bit sri, input bit rot, input int unsigned d);
        bit use_rot;
        int unsigned fill;
`ifdef SRN_ROTATE_EN
        use_rot = rot;
`else
        use_rot = 1'b0;
`endif
        if (r) begin
            m_q    = INIT_VAL;
            m_cnt  = 0;
            m_done = 1'b0;
        end else if (!ce || md == 0) begin
            m_done = 1'b0;
        end else if (md == 3) begin
            m_q    = d;
            m_cnt  = 0;
            m_done = 1'b0;
        end else begin
            if (md == 1) begin
                fill = use_rot ? m_q / 128 : sli;
                m_q  = (m_q * 2 + fill) % 256;
            end else begin
                fill = use_rot ? m_q % 2 : sri;
                m_q  = m_q / 2 + fill * 128;
            end
            m_done = (m_cnt + 1 == W);
            m_cnt  = (m_cnt + 1 > W) ? W : m_cnt + 1;
        end
    endtask

    // Drive one cycle of inputs from the falling edge. The model is updated
    // at the rising edge, and every output is compared at the next falling
    // edge.
    task automatic applyStimulus(input bit r, input bit ce, input logic [1:0] md, input bit sli,
                                 input bit sri, input bit rot, input logic [7:0] d);
        R    = r;
        CE   = ce;
        MODE = md;
        SLI  = sli;
        SRI  = sri;
        ROT  = rot;
        D    = d;
        @(posedge CLK);
        modelStep(r, ce, int'(md), sli, sri, rot, int'(d));
        @(negedge CLK);
        checkAll();
        if (DONE) done_seen++;
    endtask

    initial begin
        R = 1'b1; CE = 1'b0; MODE = 2'b00; SLI = 1'b0; SRI = 1'b0; ROT = 1'b0; D = 8'h00;
        @(negedge CLK);

        // Reset for two cycles, then hold with CE low.
        applyStimulus(1, 0, 2'b00, 0, 0, 0, 8'h00);
        applyStimulus(1, 1, 2'b11, 0, 0, 0, 8'h3C);
        checkOutput("reset_q", 64'(Q), 64'h A5);
        checkOutput("reset_cnt", 64'(CNT), 64'h0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 2'b01, 1, 1, 0, 8'hFF);
        checkOutput("ce_hold_q", 64'(Q), 64'h A5);

        // Shift-left fill from zero.
        applyStimulus(0, 1, 2'b11, 0, 0, 0, 8'h00);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 2'b01, 1, 0, 0, 8'h00);
            checkOutput("fill_q", 64'(Q), 64'((1 << (i + 1)) - 1));
        end
        checkOutput("fill_full", 64'(FULL), 64'h1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 2'b01, 1, 0, 0, 8'h00);
        checkOutput("fill_cnt_sat", 64'(CNT), 64'h8);
        checkOutput("fill_done_pulses", 64'(done_seen), 64'h1);

        // Load 96, then shift right and watch SRO.
        applyStimulus(0, 1, 2'b11, 0, 0, 0, 8'h96);
        checkOutput("load_q", 64'(Q), 64'h96);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("sro_seq", 64'(SRO), 64'(exp_sro[i]));
            applyStimulus(0, 1, 2'b10, 0, 0, 0, 8'h00);
        end
        checkOutput("shr_final_q", 64'(Q), 64'h00);
        checkOutput("shr_done_pulses", 64'(done_seen), 64'h1);

        // Gate CE in the middle of a word, then reset with CE low.
        applyStimulus(0, 1, 2'b11, 0, 0, 0, 8'hF0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 2'b01, 0, 0, 0, 8'h00);
        checkOutput("mid_q", 64'(Q), 64'h80);
        checkOutput("mid_cnt", 64'(CNT), 64'h3);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 2'b01, 1, 1, 0, 8'h00);
        checkOutput("gated_q", 64'(Q), 64'h80);
        applyStimulus(1, 0, 2'b01, 0, 0, 0, 8'h00);
        checkOutput("mid_reset_q", 64'(Q), 64'h A5);

        // Rotate request. The result depends on whether rotation is built in.
        applyStimulus(0, 1, 2'b11, 0, 0, 0, 8'h81);
        done_seen = 0;
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 2'b01, 0, 0, 1, 8'h00);
`ifdef SRN_ROTATE_EN
        checkOutput("rot_q", 64'(Q), 64'h81);
`else
        checkOutput("rot_q", 64'(Q), 64'h00);
`endif
        checkOutput("rot_done_pulses", 64'(done_seen), 64'h1);

        // Randomised run against the model. Reset is rare so that words
        // have time to complete.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
                          2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                          1'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
